// File: rtl/out_frame_pingpong_ctrl.sv
// Two-bank output frame buffer arbiter between a never-stalled frame writer and a host reader.
// Latest-frame-wins: unread completed frames are overwritten by the writer and counted in drop_cnt.
module out_frame_pingpong_ctrl #(
    parameter int OUT_WIDTH  = 64,
    parameter int OUT_HEIGHT = 32,
    localparam int NPIX   = OUT_WIDTH * OUT_HEIGHT,
    localparam int ADDR_W = $clog2(NPIX)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pp_wr_en,
    input  logic [ADDR_W-1:0] pp_wr_addr,
    input  logic [7:0]        pp_wr_data,
    input  logic              rd_start,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_release,
    output logic              bram_wr_en,
    output logic [ADDR_W:0]   bram_wr_addr,
    output logic [7:0]        bram_wr_data,
    output logic              bram_rd_en,
    output logic [ADDR_W:0]   bram_rd_addr,
    input  logic [7:0]        bram_rd_data,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    output logic              frame_ready,
    output logic              rd_busy,
    output logic [15:0]       drop_cnt,
    output logic              wr_err
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NPIX - 1);

    localparam logic [1:0] ST_FREE    = 2'd0;
    localparam logic [1:0] ST_WRITING = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;
    localparam logic [1:0] ST_READING = 2'd3;

    logic [1:0][1:0] bank_st_q, bank_st_d;
    logic            wr_active_q, wr_active_d;
    logic            wr_bank_q, wr_bank_d;
    logic            newest_q, newest_d;
    logic            rd_bank_q, rd_bank_d;
    logic            rd_busy_q, rd_busy_d;
    logic            rd_valid_q, rd_valid_d;
    logic            frame_ready_q, frame_ready_d;
    logic [15:0]     drop_cnt_q, drop_cnt_d;
    logic            wr_err_q, wr_err_d;

    logic            wr_start, wr_end, rd_claim, rd_free;
    logic            claim_bank, rd_pick;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_st_q     <= {ST_FREE, ST_FREE};
            wr_active_q   <= 1'b0;
            wr_bank_q     <= 1'b0;
            newest_q      <= 1'b0;
            rd_bank_q     <= 1'b0;
            rd_busy_q     <= 1'b0;
            rd_valid_q    <= 1'b0;
            frame_ready_q <= 1'b0;
            drop_cnt_q    <= 16'd0;
            wr_err_q      <= 1'b0;
        end else begin
            bank_st_q     <= bank_st_d;
            wr_active_q   <= wr_active_d;
            wr_bank_q     <= wr_bank_d;
            newest_q      <= newest_d;
            rd_bank_q     <= rd_bank_d;
            rd_busy_q     <= rd_busy_d;
            rd_valid_q    <= rd_valid_d;
            frame_ready_q <= frame_ready_d;
            drop_cnt_q    <= drop_cnt_d;
            wr_err_q      <= wr_err_d;
        end
    end

    // Bank selection. With both banks empty the writer always starts in bank 0 so a
    // fresh (or freshly reset) pipeline is deterministic; otherwise prefer the older slot.
    always_comb begin
        if (bank_st_q[0] == ST_FREE && bank_st_q[1] == ST_FREE)
            claim_bank = 1'b0;
        else if (bank_st_q[~newest_q] == ST_FREE)
            claim_bank = ~newest_q;
        else if (bank_st_q[newest_q] == ST_FREE)
            claim_bank = newest_q;
        else if (bank_st_q[~newest_q] == ST_FULL)
            claim_bank = ~newest_q;
        else
            claim_bank = newest_q;
        rd_pick = (bank_st_q[newest_q] == ST_FULL) ? newest_q : ~newest_q;
    end

    // Next-state logic
    always_comb begin
        wr_start = !wr_active_q && pp_wr_en && (pp_wr_addr == '0);
        wr_end   = wr_active_q && pp_wr_en && (pp_wr_addr == LAST);
        rd_claim = rd_start && frame_ready_q && !rd_busy_q;
        rd_free  = rd_release && rd_busy_q;

        bank_st_d   = bank_st_q;
        wr_active_d = wr_active_q;
        wr_bank_d   = wr_bank_q;
        newest_d    = newest_q;
        rd_bank_d   = rd_bank_q;
        rd_busy_d   = rd_busy_q;
        drop_cnt_d  = drop_cnt_q;
        wr_err_d    = wr_err_q;

        if (wr_start) begin
            bank_st_d[claim_bank] = ST_WRITING;
            wr_bank_d             = claim_bank;
            wr_active_d           = 1'b1;
            if (bank_st_q[claim_bank] == ST_FULL && drop_cnt_q != 16'hFFFF)
                drop_cnt_d = drop_cnt_q + 16'd1;
        end
        // Out-of-sequence start, or a restart inside a frame (the bank is simply rewritten)
        if (pp_wr_en && ((!wr_active_q && pp_wr_addr != '0) || (wr_active_q && pp_wr_addr == '0)))
            wr_err_d = 1'b1;
        if (wr_end) begin
            bank_st_d[wr_bank_q] = ST_FULL;
            newest_d             = wr_bank_q;
            wr_active_d          = 1'b0;
        end

        if (rd_claim) begin
            bank_st_d[rd_pick] = ST_READING;
            rd_bank_d          = rd_pick;
            rd_busy_d          = 1'b1;
        end
        if (rd_free) begin
            bank_st_d[rd_bank_q] = ST_FREE;
            rd_busy_d            = 1'b0;
        end

        frame_ready_d = (bank_st_d[0] == ST_FULL) || (bank_st_d[1] == ST_FULL);
        rd_valid_d    = rd_en && rd_busy_q;
    end

    // Outputs
    always_comb begin
        bram_wr_en   = pp_wr_en && (wr_active_q || pp_wr_addr == '0);
        bram_wr_addr = {(wr_active_q ? wr_bank_q : claim_bank), pp_wr_addr};
        bram_wr_data = pp_wr_data;
        bram_rd_en   = rd_en && rd_busy_q;
        bram_rd_addr = {rd_bank_q, rd_addr};
        rd_data      = bram_rd_data;
        rd_valid     = rd_valid_q;
        frame_ready  = frame_ready_q;
        rd_busy      = rd_busy_q;
        drop_cnt     = drop_cnt_q;
        wr_err       = wr_err_q;
    end

endmodule

// File: tb/tb_out_frame_pingpong_ctrl.sv
// Directed bench with a scoreboard: stimulus pushes expected BRAM writes / host reads,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_out_frame_pingpong_ctrl;
    localparam int W  = 64;
    localparam int H  = 32;
    localparam int N  = W * H;
    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          pp_wr_en;
    logic [AW-1:0] pp_wr_addr;
    logic [7:0]    pp_wr_data;
    logic          rd_start, rd_en, rd_release;
    logic [AW-1:0] rd_addr;
    logic          bram_wr_en, bram_rd_en;
    logic [AW:0]   bram_wr_addr, bram_rd_addr;
    logic [7:0]    bram_wr_data, bram_rd_data, rd_data;
    logic          rd_valid, frame_ready, rd_busy, wr_err;
    logic [15:0]   drop_cnt;

    int checks = 0;
    int failures = 0;
    logic [19:0] wq[$];
    logic [7:0]  rq[$];
    logic [7:0]  mem [0:2*N-1];

    always #5 clk = ~clk;

    out_frame_pingpong_ctrl #(.OUT_WIDTH(W), .OUT_HEIGHT(H)) dut (
        .clk(clk), .rst(rst),
        .pp_wr_en(pp_wr_en), .pp_wr_addr(pp_wr_addr), .pp_wr_data(pp_wr_data),
        .rd_start(rd_start), .rd_en(rd_en), .rd_addr(rd_addr), .rd_release(rd_release),
        .bram_wr_en(bram_wr_en), .bram_wr_addr(bram_wr_addr), .bram_wr_data(bram_wr_data),
        .bram_rd_en(bram_rd_en), .bram_rd_addr(bram_rd_addr), .bram_rd_data(bram_rd_data),
        .rd_data(rd_data), .rd_valid(rd_valid), .frame_ready(frame_ready),
        .rd_busy(rd_busy), .drop_cnt(drop_cnt), .wr_err(wr_err)
    );

    // Behavioural BRAM, 1-cycle read latency
    always @(posedge clk) begin
        if (bram_wr_en) mem[bram_wr_addr] <= bram_wr_data;
        if (bram_rd_en) bram_rd_data <= mem[bram_rd_addr];
    end

    function automatic logic [7:0] pat(int fid, int a);
        return 8'((a * 7) ^ (fid * 29) ^ (a >> 8));
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every presented write / read must match the head of its queue
    always @(negedge clk) begin
        if (!rst) begin
            if (bram_wr_en) begin
                checks++;
                if (wq.size() == 0) begin
                    failures++;
                    $display("FAIL wr_unexpected actual=%0h/%0h expected=none", bram_wr_addr, bram_wr_data);
                end else begin
                    logic [19:0] e;
                    e = wq.pop_front();
                    if ({bram_wr_addr, bram_wr_data} !== e) begin
                        failures++;
                        $display("FAIL bram_wr actual=%0h/%0h expected=%0h/%0h",
                                 bram_wr_addr, bram_wr_data, e[19:8], e[7:0]);
                    end
                end
            end
            if (rd_valid) begin
                checks++;
                if (rq.size() == 0) begin
                    failures++;
                    $display("FAIL rd_unexpected actual=%0h expected=none", rd_data);
                end else begin
                    logic [7:0] e;
                    e = rq.pop_front();
                    if (rd_data !== e) begin
                        failures++;
                        $display("FAIL rd_data actual=%0h expected=%0h", rd_data, e);
                    end
                end
            end
        end
    end

    task automatic idle_inputs;
        pp_wr_en = 0; pp_wr_addr = '0; pp_wr_data = '0;
        rd_start = 0; rd_en = 0; rd_addr = '0; rd_release = 0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1;
        tick(); tick();
        chk("rst_bram_wr_en", 32'(bram_wr_en), 0);
        chk("rst_bram_wr_addr", 32'(bram_wr_addr), 0);
        chk("rst_bram_rd_en", 32'(bram_rd_en), 0);
        chk("rst_bram_rd_addr", 32'(bram_rd_addr), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_frame_ready", 32'(frame_ready), 0);
        chk("rst_rd_busy", 32'(rd_busy), 0);
        chk("rst_drop_cnt", 32'(drop_cnt), 0);
        chk("rst_wr_err", 32'(wr_err), 0);
        rst = 0;
        tick();
    endtask

    // Stream n bytes of frame fid; expect them in the given bank. Optionally pulse rd_start on the last byte.
    task automatic stream(int fid, int bank, int n, bit rs_at_last);
        for (int a = 0; a < n; a++) begin
            pp_wr_en   = 1;
            pp_wr_addr = AW'(a);
            pp_wr_data = pat(fid, a);
            wq.push_back({1'(bank), AW'(a), pat(fid, a)});
            if (rs_at_last && a == n - 1) rd_start = 1;
            tick();
        end
        pp_wr_en = 0; pp_wr_addr = '0; rd_start = 0;
    endtask

    task automatic claim;
        rd_start = 1;
        tick();
        rd_start = 0;
    endtask

    task automatic release_rd;
        rd_release = 1;
        tick();
        rd_release = 0;
    endtask

    task automatic read_chk(string name, int fid, int bank, int a);
        rd_en   = 1;
        rd_addr = AW'(a);
        #1;
        chk({name, "_rd_en"}, 32'(bram_rd_en), 1);
        chk({name, "_rd_addr"}, 32'(bram_rd_addr), 32'(bank * N + a));
        rq.push_back(pat(fid, a));
        tick();
        rd_en = 0;
        tick();
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        do_reset();

        // Single frame into bank 0, then host read and release
        stream(1, 0, N, 0);
        chk("f1_frame_ready", 32'(frame_ready), 1);
        chk("f1_drop_cnt", 32'(drop_cnt), 0);
        chk("f1_rd_busy", 32'(rd_busy), 0);
        claim();
        chk("f1_claim_busy", 32'(rd_busy), 1);
        read_chk("f1_a5", 1, 0, 5);
        release_rd();
        chk("f1_rel_busy", 32'(rd_busy), 0);
        chk("f1_rel_ready", 32'(frame_ready), 0);

        // Three frames, no reader: banks 0,1,0 and one drop
        stream(2, 0, N, 0);
        stream(3, 1, N, 0);
        stream(4, 0, N, 0);
        chk("f3_drop_cnt", 32'(drop_cnt), 1);
        claim();
        chk("f3_claim_busy", 32'(rd_busy), 1);
        read_chk("f3_a9", 4, 0, 9);
        release_rd();

        // Reader holds bank 0 while two frames land in bank 1
        do_reset();
        stream(5, 0, N, 0);
        claim();
        stream(6, 1, N, 0);
        stream(7, 1, N, 0);
        chk("hold_drop_cnt", 32'(drop_cnt), 1);
        chk("hold_ready", 32'(frame_ready), 1);
        read_chk("hold_a100", 5, 0, 100);
        release_rd();
        claim();
        chk("hold_claim2", 32'(rd_busy), 1);
        read_chk("hold_b1_a3", 7, 1, 3);
        release_rd();

        // Frame end and rd_start in the same cycle from empty
        stream(8, 0, N, 1);
        chk("same_busy", 32'(rd_busy), 0);
        chk("same_ready", 32'(frame_ready), 1);
        claim();
        chk("same_claim_next", 32'(rd_busy), 1);
        read_chk("same_last", 8, 0, N - 1);
        release_rd();

        // Stray strobe while idle
        pp_wr_en   = 1;
        pp_wr_addr = AW'(7);
        pp_wr_data = 8'hA5;
        #1;
        chk("stray_no_wr", 32'(bram_wr_en), 0);
        tick();
        pp_wr_en = 0; pp_wr_addr = '0;
        chk("stray_wr_err", 32'(wr_err), 1);
        chk("stray_ready", 32'(frame_ready), 0);

        // Reset mid-frame, then a fresh frame lands in bank 0
        stream(9, 0, 100, 0);
        do_reset();
        stream(10, 0, N, 0);
        chk("post_rst_ready", 32'(frame_ready), 1);
        chk("post_rst_drop", 32'(drop_cnt), 0);
        claim();
        read_chk("post_rst_a0", 10, 0, 0);
        release_rd();

        tick();
        chk("wq_drained", 32'(wq.size()), 0);
        chk("rq_drained", 32'(rq.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
